// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared header layout, FSM state type and header builder for the NoC packet injector
package noc_pkg;

   // Header is assembled left-aligned in a wide word; the top FLIT_WIDTH bits form the flit.
   localparam int HDR_W   = 128;
   localparam int DEST_HI = 0;
   localparam int SRC_HI  = 4;
   localparam int LEN_HI  = 8;

   typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

   function automatic logic [HDR_W-1:0] build_header(
      input logic [1:0]  dest_x,
      input logic [1:0]  dest_y,
      input logic [1:0]  src_x,
      input logic [1:0]  src_y,
      input logic [15:0] len,
      input int          lenw
   );
      logic [HDR_W-1:0] h;
      h = '0;
      h[HDR_W-1-DEST_HI -: 4] = {dest_x, dest_y};
      h[HDR_W-1-SRC_HI  -: 4] = {src_x, src_y};
      h = h | (HDR_W'(len) << (HDR_W - LEN_HI - lenw));
      return h;
   endfunction

endpackage

// File: rtl/noc_packet_injector.sv
// rtl/noc_packet_injector.sv - local-port packetizer: header flit then payload body flits on one VC
// Optional NOC_INJECTOR_PKTCNT_EN adds a 16-bit count of completed packets (pkt_count).
module noc_packet_injector
   import noc_pkg::*;
#(
   parameter int         FLIT_WIDTH = 32,
   parameter int         VCHANNELS  = 2,
   parameter logic [1:0] X          = 2'd0,
   parameter logic [1:0] Y          = 2'd0,
   parameter int         MAX_LEN    = 8,
   localparam int        LENW       = $clog2(MAX_LEN + 1),
   localparam int        VCW        = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_dest_x,
   input  logic [1:0]            req_dest_y,
   input  logic [VCW-1:0]        req_vc,
   input  logic [LENW-1:0]       req_len,
   input  logic                  data_valid,
   output logic                  data_ready,
   input  logic [FLIT_WIDTH-1:0] data_flit,
   output logic [FLIT_WIDTH-1:0] out_flit,
   output logic                  out_last,
   output logic [VCHANNELS-1:0]  out_valid,
   input  logic [VCHANNELS-1:0]  out_ready,
   output logic                  err_len
`ifdef NOC_INJECTOR_PKTCNT_EN
   ,
   output logic [15:0]           pkt_count
`endif
);

   state_t           state, state_nxt;
   logic [1:0]       dest_x_q, dest_y_q;
   logic [VCW-1:0]   vc_q;
   logic [LENW-1:0]  len_q, cnt;
   logic             err_q;
   logic             len_bad, req_fire, sel_ready;
   logic [HDR_W-1:0] hdr;
   logic             hdr_unused;

   assign len_bad    = req_len > LENW'(MAX_LEN);
   assign req_fire   = req_valid & req_ready;
   assign sel_ready  = out_ready[vc_q];
   assign hdr        = build_header(dest_x_q, dest_y_q, X, Y, 16'(len_q), LENW);
   assign hdr_unused = ^hdr[HDR_W-FLIT_WIDTH-1:0];
   assign err_len    = err_q;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_fire && !len_bad) state_nxt = HEAD;
         HEAD:    if (sel_ready) state_nxt = (cnt == '0) ? IDLE : BODY;
         BODY:    if (data_valid && sel_ready && cnt == LENW'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // BODY is a straight combinational pass-through of the data port onto the selected VC.
   always_comb begin
      req_ready  = 1'b0;
      data_ready = 1'b0;
      out_valid  = '0;
      out_flit   = '0;
      out_last   = 1'b0;
      case (state)
         IDLE: req_ready = 1'b1;
         HEAD: begin
            out_valid[vc_q] = 1'b1;
            out_flit        = hdr[HDR_W-1 -: FLIT_WIDTH];
            out_last        = (cnt == '0);
         end
         BODY: begin
            out_valid[vc_q] = data_valid;
            out_flit        = data_flit;
            data_ready      = sel_ready;
            out_last        = (cnt == LENW'(1));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dest_x_q <= '0;
         dest_y_q <= '0;
         vc_q     <= '0;
         len_q    <= '0;
         cnt      <= '0;
         err_q    <= 1'b0;
      end else begin
         err_q <= req_fire && len_bad;
         if (req_fire && !len_bad) begin
            dest_x_q <= req_dest_x;
            dest_y_q <= req_dest_y;
            vc_q     <= req_vc;
            len_q    <= req_len;
            cnt      <= req_len;
         end else if (state == BODY && data_valid && sel_ready) begin
            cnt <= cnt - LENW'(1);
         end
      end
   end

`ifdef NOC_INJECTOR_PKTCNT_EN
   logic xfer;
   assign xfer = |(out_valid & out_ready);

   always_ff @(posedge clk) begin
      if (rst)                   pkt_count <= '0;
      else if (xfer && out_last) pkt_count <= pkt_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_noc_packet_injector.sv
// tb/tb_noc_packet_injector.sv - self-checking bench for noc_packet_injector (X=1, Y=0, 2 VCs, MAX_LEN=8)
module tb_noc_packet_injector;

   localparam int FW   = 32;
   localparam int VCH  = 2;
   localparam int MAXL = 8;
   localparam int LENW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid, req_ready;
   logic [1:0]      req_dest_x, req_dest_y;
   logic            req_vc;
   logic [LENW-1:0] req_len;
   logic            data_valid, data_ready;
   logic [FW-1:0]   data_flit, out_flit;
   logic            out_last;
   logic [VCH-1:0]  out_valid, out_ready;
   logic            err_len;
`ifdef NOC_INJECTOR_PKTCNT_EN
   logic [15:0]     pkt_count;
`endif

   always #5 clk = ~clk;

   noc_packet_injector #(
      .FLIT_WIDTH(FW), .VCHANNELS(VCH), .X(2'd1), .Y(2'd0), .MAX_LEN(MAXL)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_dest_x(req_dest_x), .req_dest_y(req_dest_y),
      .req_vc(req_vc), .req_len(req_len),
      .data_valid(data_valid), .data_ready(data_ready), .data_flit(data_flit),
      .out_flit(out_flit), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .err_len(err_len)
`ifdef NOC_INJECTOR_PKTCNT_EN
      , .pkt_count(pkt_count)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   int exp_pkts = 0;

   typedef struct {
      logic        vc;
      logic [1:0]  dx;
      logic [1:0]  dy;
      logic [3:0]  len;
      int          rmode;
      int          dgap;
      logic [31:0] exp_hdr;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Header from the field layout: {dest_x,dest_y,src_x=1,src_y=0,len,zeros}.
   function automatic logic [31:0] model_header(input logic [1:0] dx, input logic [1:0] dy,
                                                input logic [3:0] len);
      return {dx, dy, 2'd1, 2'd0, len, 20'd0};
   endfunction

   task automatic check_pkt_count();
`ifdef NOC_INJECTOR_PKTCNT_EN
      check("pkt_count", pkt_count, 64'(exp_pkts));
`endif
   endtask

   task automatic run_packet(input logic vc, input logic [1:0] dx, input logic [1:0] dy,
                             input logic [3:0] len, input int rmode, input int dgap,
                             input logic [31:0] exp_hdr);
      logic [31:0] payload[$];
      logic [1:0]  oh;
      int          k;
      int          cyc;
      oh = 2'b01 << vc;
      payload.delete();
      for (int i = 0; i < int'(len); i++) payload.push_back($urandom);
      req_valid  = 1'b1;
      req_dest_x = dx;
      req_dest_y = dy;
      req_vc     = vc;
      req_len    = len;
      data_valid = 1'b0;
      out_ready  = 2'($urandom);
      @(negedge clk);
      check("req_ready_idle", req_ready, 1);
      check("idle_no_valid", out_valid, 0);
      check("idle_no_dready", data_ready, 0);
      @(posedge clk); #1;
      k = 0;
      cyc = 0;
      while (k <= int'(len) && cyc < 200) begin
         req_valid  = 1'($urandom);
         req_vc     = 1'($urandom);
         req_len    = 4'($urandom_range(0, MAXL));
         case (rmode)
            0: out_ready = 2'b11;
            1: begin
               out_ready     = 2'($urandom);
               out_ready[vc] = (cyc % 2 == 0);
            end
            default: out_ready = 2'($urandom);
         endcase
         data_valid = (dgap != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
         data_flit  = (k >= 1) ? payload[k-1] : $urandom;
         @(negedge clk);
         check("vld_onehot0", 64'($countones(out_valid) <= 1), 1);
         check("req_ready_busy", req_ready, 0);
         if (k == 0) begin
            check("hdr_valid", out_valid, oh);
            check("hdr_flit", out_flit, exp_hdr);
            check("hdr_last", out_last, len == 0);
            check("hdr_dready", data_ready, 0);
         end else begin
            check("body_valid", out_valid, data_valid ? oh : 2'b00);
            check("body_dready", data_ready, out_ready[vc]);
            check("body_last", out_last, k == int'(len));
            if (data_valid) check("body_flit", out_flit, payload[k-1]);
         end
         if (out_valid[vc] && out_ready[vc]) k++;
         @(posedge clk); #1;
         cyc++;
      end
      check("pkt_timeout", 64'(cyc < 200), 1);
      req_valid  = 1'b0;
      data_valid = 1'b1;
      out_ready  = 2'b11;
      exp_pkts++;
      @(negedge clk);
      check("post_idle_valid", out_valid, 0);
      check("post_req_ready", req_ready, 1);
      check("post_dready", data_ready, 0);
      check_pkt_count();
      @(posedge clk); #1;
   endtask

   initial begin
      vecs[0] = '{1'b1, 2'd2, 2'd3, 4'd0, 0, 0, 32'hB400_0000};
      vecs[1] = '{1'b0, 2'd1, 2'd2, 4'd3, 1, 0, 32'h6430_0000};
      vecs[2] = '{1'b1, 2'd3, 2'd3, 4'd8, 0, 1, 32'hF480_0000};
      vecs[3] = '{1'b0, 2'd0, 2'd0, 4'd1, 2, 1, 32'h0410_0000};
      vecs[4] = '{1'b1, 2'd0, 2'd1, 4'd5, 2, 1, 32'h1450_0000};
      vecs[5] = '{1'b0, 2'd2, 2'd0, 4'd8, 1, 1, 32'h8480_0000};
      vecs[6] = '{1'b1, 2'd1, 2'd1, 4'd2, 2, 0, 32'h5420_0000};

      rst = 1'b1; req_valid = 1'b0; req_dest_x = '0; req_dest_y = '0; req_vc = '0;
      req_len = '0; data_valid = 1'b0; data_flit = '0; out_ready = 2'b11;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", req_ready, 1);
      check("rst_data_ready", data_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_flit", out_flit, 0);
      check("rst_err_len", err_len, 0);
      check_pkt_count();
      @(posedge clk); #1;
      rst = 1'b0;

      foreach (vecs[i])
         run_packet(vecs[i].vc, vecs[i].dx, vecs[i].dy, vecs[i].len,
                    vecs[i].rmode, vecs[i].dgap, vecs[i].exp_hdr);

      // Oversized request: consumed, one-cycle err_len, no flits.
      req_valid = 1'b1; req_len = 4'd9; req_vc = 1'b1; out_ready = 2'b11;
      @(negedge clk);
      check("err_req_ready", req_ready, 1);
      check("err_pre", err_len, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("err_pulse", err_len, 1);
      check("err_no_valid", out_valid, 0);
      check("err_idle_ready", req_ready, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("err_pulse_end", err_len, 0);
      check("err_no_valid2", out_valid, 0);
      check_pkt_count();
      @(posedge clk); #1;

      for (int n = 0; n < 12; n++) begin
         logic       rvc;
         logic [1:0] rdx, rdy;
         logic [3:0] rlen;
         rvc  = 1'($urandom);
         rdx  = 2'($urandom);
         rdy  = 2'($urandom);
         rlen = 4'($urandom_range(0, MAXL));
         run_packet(rvc, rdx, rdy, rlen, 2, 1, model_header(rdx, rdy, rlen));
      end

      // Reset in BODY after header and two of five payload words.
      req_valid = 1'b1; req_dest_x = 2'd3; req_dest_y = 2'd1; req_vc = 1'b0; req_len = 4'd5;
      out_ready = 2'b11; data_valid = 1'b1; data_flit = 32'hA5A5_0001;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("mid_hdr_flit", out_flit, model_header(2'd3, 2'd1, 4'd5));
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_body0", out_flit, 32'hA5A5_0001);
      @(posedge clk); #1;
      data_flit = 32'hA5A5_0002;
      @(negedge clk);
      check("mid_body1", out_flit, 32'hA5A5_0002);
      check("mid_body1_valid", out_valid, 2'b01);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_pkts = 0;
      @(negedge clk);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_dready", data_ready, 0);
      check("mid_rst_req_ready", req_ready, 1);
      check_pkt_count();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
